// File: rtl/pet_pkg.sv
// Shared types, default parameters and helpers for the pet needs engine.
package pet_pkg;

    typedef enum logic [1:0] {
        MOOD_OK    = 2'b00,
        MOOD_NEEDY = 2'b01,
        MOOD_SICK  = 2'b10,
        MOOD_DEAD  = 2'b11
    } mood_t;

    localparam int unsigned DEF_N_NEEDS     = 3;
    localparam int unsigned DEF_STAT_W      = 4;
    localparam int unsigned DEF_TICK_DIV    = 1000;
    localparam int unsigned DEF_DECAY_TICKS = 8;
    localparam int unsigned DEF_CARE_STEP   = 4;
    localparam int unsigned DEF_SICK_TICKS  = 16;

    // A stat below a quarter of full scale counts as low.
    function automatic int unsigned low_th(int unsigned stat_w);
        return 32'd1 << (stat_w - 32'd2);
    endfunction

endpackage

// File: rtl/pet_stat_cell.sv
// One saturating pet statistic: press edge detector, decay and care step.
module pet_stat_cell
    import pet_pkg::*;
#(
    parameter int unsigned STAT_W    = DEF_STAT_W,
    parameter int unsigned CARE_STEP = DEF_CARE_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              freeze,
    input  logic              decay,
    input  logic              btn,
    output logic [STAT_W-1:0] stat,
    output logic              is_low,
    output logic              is_zero
);

    localparam int unsigned MAX  = (32'd1 << STAT_W) - 32'd1;
    localparam int unsigned STEP = (CARE_STEP > MAX) ? MAX : CARE_STEP;

    localparam logic [STAT_W-1:0] MAX_VAL  = STAT_W'(MAX);
    localparam logic [STAT_W:0]   STEP_VAL = (STAT_W + 1)'(STEP);
    localparam logic [STAT_W-1:0] LOW_VAL  = STAT_W'(low_th(STAT_W));

    logic              btn_q;
    logic              press;
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_d;
    logic [STAT_W-1:0] decayed;
    logic [STAT_W:0]   sum;

    assign press = en & btn & ~btn_q;

    // Edge detector tracks the button only while running; resets high so a held
    // button is not seen as a press on reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
        end else if (en) begin
            btn_q <= btn;
        end
    end

    // Decay first, then the care step, each saturating.
    always_comb begin
        decayed = stat_q;
        if (decay && (stat_q != '0)) begin
            decayed = stat_q - STAT_W'(1);
        end
        sum    = {1'b0, decayed} + STEP_VAL;
        stat_d = stat_q;
        if (en && !freeze) begin
            stat_d = decayed;
            if (press) begin
                stat_d = (sum > {1'b0, MAX_VAL}) ? MAX_VAL : sum[STAT_W-1:0];
            end
        end
    end

    // Stat register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= MAX_VAL;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat    = stat_q;
    assign is_low  = (stat_q < LOW_VAL);
    assign is_zero = (stat_q == '0);

endmodule

// File: rtl/pet_needs_engine.sv
// Needs-and-mood engine: prescaled game tick, periodic decay of all stats,
// care presses per need, and a mood FSM escalating to an absorbing DEAD.
module pet_needs_engine
    import pet_pkg::*;
#(
    parameter int unsigned N_NEEDS     = DEF_N_NEEDS,
    parameter int unsigned STAT_W      = DEF_STAT_W,
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned DECAY_TICKS = DEF_DECAY_TICKS,
    parameter int unsigned CARE_STEP   = DEF_CARE_STEP,
    parameter int unsigned SICK_TICKS  = DEF_SICK_TICKS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [N_NEEDS-1:0]          btn_care,
    output logic [N_NEEDS*STAT_W-1:0]   stat,
    output logic [1:0]                  mood,
    output logic                        alert,
    output logic                        tick
);

    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEC_W  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int unsigned SICK_W = $clog2(SICK_TICKS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECAY_TICKS - 1);
    localparam logic [SICK_W-1:0] SICK_LAST = SICK_W'(SICK_TICKS - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic [SICK_W-1:0] sick_q, sick_d;
    logic              tick_q;
    logic              alert_q, alert_d;
    mood_t             mood_q, mood_d;

    logic               game_tick;
    logic               decay_now;
    logic               dead;
    logic [N_NEEDS-1:0] low_vec;
    logic [N_NEEDS-1:0] zero_vec;
    logic               any_low;
    logic               any_zero;

    assign game_tick = ena && (pre_q == PRE_LAST);
    assign decay_now = game_tick && (dec_q == DEC_LAST);
    assign dead      = (mood_q == MOOD_DEAD);
    assign any_low   = |low_vec;
    assign any_zero  = |zero_vec;

    // Prescaler and decay counter next state; both hold while ena is low.
    always_comb begin
        pre_d = pre_q;
        dec_d = dec_q;
        if (ena) begin
            pre_d = game_tick ? '0 : pre_q + PRE_W'(1);
        end
        if (game_tick) begin
            dec_d = decay_now ? '0 : dec_q + DEC_W'(1);
        end
    end

    // Prescaler, decay counter and registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            dec_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            dec_q  <= dec_d;
            tick_q <= game_tick;
        end
    end

    for (genvar i = 0; i < N_NEEDS; i++) begin : g_need
        pet_stat_cell #(
            .STAT_W    (STAT_W),
            .CARE_STEP (CARE_STEP)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ena),
            .freeze  (dead),
            .decay   (decay_now),
            .btn     (btn_care[i]),
            .stat    (stat[i*STAT_W +: STAT_W]),
            .is_low  (low_vec[i]),
            .is_zero (zero_vec[i])
        );
    end

    // Mood FSM next state from the current stats; sick counter lives with it.
    always_comb begin
        mood_d = mood_q;
        sick_d = sick_q;
        if (ena) begin
            case (mood_q)
                MOOD_DEAD: begin
                    mood_d = MOOD_DEAD;
                end
                MOOD_SICK: begin
                    if (!any_zero) begin
                        mood_d = any_low ? MOOD_NEEDY : MOOD_OK;
                        sick_d = '0;
                    end else if (game_tick) begin
                        sick_d = sick_q + SICK_W'(1);
                        if (sick_q == SICK_LAST) begin
                            mood_d = MOOD_DEAD;
                        end
                    end
                end
                default: begin
                    if (any_zero) begin
                        mood_d = MOOD_SICK;
                    end else if (any_low) begin
                        mood_d = MOOD_NEEDY;
                    end else begin
                        mood_d = MOOD_OK;
                    end
                end
            endcase
        end
        alert_d = (mood_d != MOOD_OK);
    end

    // Mood, alert and sick counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mood_q  <= MOOD_OK;
            alert_q <= 1'b0;
            sick_q  <= '0;
        end else begin
            mood_q  <= mood_d;
            alert_q <= alert_d;
            sick_q  <= sick_d;
        end
    end

    assign mood  = mood_q;
    assign alert = alert_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_pet_needs_engine.sv
// Self-checking bench for pet_needs_engine: a cycle model feeds a scoreboard
// queue, plus scenario tasks with targeted checks.
module tb_pet_needs_engine;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 4;
    localparam int unsigned TD = 4;
    localparam int unsigned DT = 2;
    localparam int unsigned CS = 4;
    localparam int unsigned ST = 3;
    localparam int          MAXV = 15;
    localparam int          LOWV = 4;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic           ena      = 1'b0;
    logic [N-1:0]   btn_care = '0;
    logic [N*W-1:0] stat;
    logic [1:0]     mood;
    logic           alert;
    logic           tick;

    pet_needs_engine #(
        .N_NEEDS     (N),
        .STAT_W      (W),
        .TICK_DIV    (TD),
        .DECAY_TICKS (DT),
        .CARE_STEP   (CS),
        .SICK_TICKS  (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_care (btn_care),
        .stat     (stat),
        .mood     (mood),
        .alert    (alert),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] stat;
        logic [1:0]     mood;
        logic           alert;
        logic           tick;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int m_stat[N];
    bit m_prev[N];
    int m_pre, m_dec, m_sick, m_mood;
    bit m_alert, m_tick;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_stat[i] = MAXV;
            m_prev[i] = 1'b1;
        end
        m_pre = 0; m_dec = 0; m_sick = 0; m_mood = 0;
        m_alert = 1'b0; m_tick = 1'b0;
    endtask

    function automatic exp_t model_pack();
        exp_t e;
        for (int i = 0; i < N; i++) e.stat[i*W +: W] = m_stat[i][W-1:0];
        e.mood  = m_mood[1:0];
        e.alert = m_alert;
        e.tick  = m_tick;
        return e;
    endfunction

    // Advance the model by one clock edge using the present inputs.
    task automatic model_edge();
        int old[N];
        bit wrap, dec, anyz, anyl, dead, press;
        int s;
        for (int i = 0; i < N; i++) old[i] = m_stat[i];
        if (!ena) begin
            m_tick = 1'b0;
            return;
        end
        wrap   = (m_pre == TD - 1);
        m_pre  = wrap ? 0 : m_pre + 1;
        m_tick = wrap;
        dec    = 1'b0;
        if (wrap) begin
            if (m_dec == DT - 1) begin m_dec = 0; dec = 1'b1; end
            else m_dec++;
        end
        anyz = 1'b0; anyl = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (old[i] == 0) anyz = 1'b1;
            if (old[i] < LOWV) anyl = 1'b1;
        end
        dead = (m_mood == 3);
        if (!dead) begin
            if (m_mood == 2) begin
                if (!anyz) begin
                    m_mood = anyl ? 1 : 0;
                    m_sick = 0;
                end else if (wrap) begin
                    m_sick++;
                    if (m_sick == ST) m_mood = 3;
                end
            end else begin
                m_mood = anyz ? 2 : (anyl ? 1 : 0);
            end
        end
        m_alert = (m_mood != 0);
        for (int i = 0; i < N; i++) begin
            press     = btn_care[i] && !m_prev[i];
            m_prev[i] = btn_care[i];
            if (!dead) begin
                s = old[i];
                if (dec && s > 0) s--;
                if (press) s = (s + CS > MAXV) ? MAXV : s + CS;
                m_stat[i] = s;
            end
        end
    endtask

    // One clock: predict, enqueue, let the edge happen, return just after it.
    task automatic step();
        model_edge();
        sb.push_back(model_pack());
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop the prediction for every edge and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if ({stat, mood, alert, tick} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got stat=%h mood=%0d alert=%0b tick=%0b want stat=%h mood=%0d alert=%0b tick=%0b",
                             $time, stat, mood, alert, tick, e.stat, e.mood, e.alert, e.tick);
                end
            end
        end
    end

    // Reset asserted and released on falling edges; caller steps next.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ena = 1'b0;
        btn_care = '0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (stat !== 12'hfff) begin errors++; $display("FAIL reset_stat got=%h want=fff", stat); end
        checks++; if (mood !== 2'd0) begin errors++; $display("FAIL reset_mood got=%0d want=0", mood); end
        checks++; if (alert !== 1'b0) begin errors++; $display("FAIL reset_alert got=%0b want=0", alert); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%0b want=0", tick); end
        apply_reset();
    endtask

    task automatic test_tick_decay();
        int n;
        apply_reset();
        ena = 1'b1;
        n = 0;
        repeat (32) begin
            step();
            if (tick === 1'b1) n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL tick_count got=%0d want=8", n); end
        checks++; if (stat !== 12'hbbb) begin errors++; $display("FAIL decay_stat got=%h want=bbb", stat); end
        checks++; if (mood !== 2'd0 || alert !== 1'b0) begin
            errors++; $display("FAIL decay_mood got mood=%0d alert=%0b want 0/0", mood, alert);
        end
    endtask

    task automatic test_care_saturate();
        apply_reset();
        ena = 1'b1;
        repeat (16) step();
        checks++; if (stat[3:0] !== 4'd13) begin errors++; $display("FAIL pre_care got=%0d want=13", stat[3:0]); end
        btn_care[0] = 1'b1; step();
        checks++; if (stat[3:0] !== 4'd15) begin errors++; $display("FAIL care_sat got=%0d want=15", stat[3:0]); end
        btn_care[0] = 1'b0; step();
        btn_care[0] = 1'b1; step();
        checks++; if (stat[3:0] !== 4'd15) begin errors++; $display("FAIL care_sat2 got=%0d want=15", stat[3:0]); end
        btn_care = 3'b000; step();
        btn_care = 3'b110; step();
        checks++; if (stat !== 12'hfff) begin errors++; $display("FAIL multi_press got=%h want=fff", stat); end
        btn_care = 3'b000; step();
    endtask

    task automatic test_needy();
        int k;
        apply_reset();
        ena = 1'b1;
        k = 0;
        while (m_stat[0] != 3 && k < 200) begin step(); k++; end
        checks++; if (k >= 200) begin errors++; $display("FAIL needy_wait got=timeout want=stat3"); end
        checks++; if (stat[3:0] !== 4'd3 || mood !== 2'd0 || alert !== 1'b0) begin
            errors++; $display("FAIL needy_pre got stat0=%0d mood=%0d alert=%0b want 3/0/0", stat[3:0], mood, alert);
        end
        step();
        checks++; if (mood !== 2'd1 || alert !== 1'b1) begin
            errors++; $display("FAIL needy got mood=%0d alert=%0b want 1/1", mood, alert);
        end
    endtask

    task automatic test_care_with_decay();
        int k;
        apply_reset();
        ena = 1'b1;
        k = 0;
        while (m_stat[1] != 5 && k < 200) begin step(); k++; end
        while (!(m_pre == TD - 1 && m_dec == DT - 1) && k < 220) begin step(); k++; end
        checks++; if (k >= 220) begin errors++; $display("FAIL cd_wait got=timeout want=decay_edge"); end
        btn_care[1] = 1'b1; step();
        checks++; if (stat[7:4] !== 4'd8 || stat[3:0] !== 4'd4) begin
            errors++; $display("FAIL care_decay got stat1=%0d stat0=%0d want 8/4", stat[7:4], stat[3:0]);
        end
        btn_care[1] = 1'b0; step();
    endtask

    task automatic test_sick_dead();
        int k, nt;
        apply_reset();
        ena = 1'b1;
        k = 0;
        while (m_mood != 2 && k < 300) begin step(); k++; end
        checks++; if (mood !== 2'd2 || alert !== 1'b1 || stat !== 12'h000) begin
            errors++; $display("FAIL sick got mood=%0d alert=%0b stat=%h want 2/1/000", mood, alert, stat);
        end
        nt = 0; k = 0;
        while (m_mood != 3 && k < 50) begin
            step(); k++;
            if (tick === 1'b1) nt++;
        end
        checks++; if (mood !== 2'd3 || nt != 3) begin
            errors++; $display("FAIL dead got mood=%0d ticks=%0d want 3/3", mood, nt);
        end
        repeat (4) begin
            btn_care = 3'b111; step();
            btn_care = 3'b000; step();
        end
        repeat (12) step();
        checks++; if (stat !== 12'h000 || mood !== 2'd3 || alert !== 1'b1) begin
            errors++; $display("FAIL dead_frozen got stat=%h mood=%0d alert=%0b want 000/3/1", stat, mood, alert);
        end
        // Asynchronous reset between clock edges
        #1 rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        checks++; if (stat !== 12'hfff || mood !== 2'd0 || alert !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL async_reset got stat=%h mood=%0d alert=%0b tick=%0b want fff/0/0/0", stat, mood, alert, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_hold_and_ena();
        int n;
        btn_care = 3'b100;
        apply_reset();
        ena = 1'b1;
        repeat (21) step();
        checks++; if (stat !== 12'hddd) begin errors++; $display("FAIL held_btn got=%h want=ddd", stat); end
        ena = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            btn_care[0] = (k % 2 == 0) && (k < 18);
            step();
            if (tick === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL ena_tick got=%0d want=0", n); end
        checks++; if (stat !== 12'hddd || mood !== 2'd0) begin
            errors++; $display("FAIL ena_hold got stat=%h mood=%0d want ddd/0", stat, mood);
        end
        ena = 1'b1;
        repeat (2) step();
        checks++; if (tick !== 1'b0 || stat !== 12'hddd) begin
            errors++; $display("FAIL resume_early got tick=%0b stat=%h want 0/ddd", tick, stat);
        end
        step();
        checks++; if (tick !== 1'b1 || stat !== 12'hccc) begin
            errors++; $display("FAIL resume_tick got tick=%0b stat=%h want 1/ccc", tick, stat);
        end
        btn_care = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_tick_decay();
        test_care_saturate();
        test_needy();
        test_care_with_decay();
        test_sick_dead();
        test_hold_and_ena();
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pet_needs_engine.md
# pet_needs_engine

Parametrised needs-and-mood engine for the tamagotchi design. It tracks N_NEEDS independent pet statistics (hunger, happiness, energy, …) that decay on a prescaled game tick and are restored by care button presses. A mood state machine derived from those statistics escalates to a terminal DEAD state. It sits between the button inputs of the top level (`ui_in`) and the display/status logic driving `uo_out`/`uio_out`.

## Interface
- N_NEEDS, 3: number of tracked needs.
- STAT_W, 4: width of each stat; MAX = 2^STAT_W-1.
- TICK_DIV, 1000: clk cycles per game tick (≥2).
- DECAY_TICKS, 8: game ticks between decrements (≥1).
- CARE_STEP, 4: increment per care press.
- SICK_TICKS, 16: game ticks tolerated in SICK before DEAD.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  high = run; low = freeze all state and ignore buttons.
- btn_care  in  N_NEEDS  synchronous level per need; a press is a 0→1 transition.
- stat  out  N_NEEDS*STAT_W  packed stats, need i at [i*STAT_W +: STAT_W].
- mood  out  2  00 OK, 01 NEEDY, 10 SICK, 11 DEAD.
- alert  out  1  high whenever mood ≠ OK.
- tick  out  1  one-cycle pulse per game tick.

## Operation
- Reset values:
  - every stat = MAX, mood = OK, alert = 0, tick = 0.
  - Prescaler, decay counter and sick counter = 0.
  - Edge-detect registers = all ones, so a button held through reset release is not a press.
- Prescaler: counts 0..TICK_DIV-1 while ena; on wrap it generates a game tick.
- Decay counter: counts game ticks 0..DECAY_TICKS-1; on wrap every stat decrements by 1, saturating at 0.
- Care: a 0→1 on btn_care[i] adds CARE_STEP to stat i, saturating at MAX. Presses on several needs in the same cycle are all applied.
- Simultaneous decay and care on the same need: new = min(max(stat-1,0)+CARE_STEP, MAX).
- Mood FSM, evaluated from the current stats, with LOW_TH = 2^(STAT_W-2):
  - OK: all stats ≥ LOW_TH.
  - NEEDY: some stat < LOW_TH and no stat is 0.
  - SICK: some stat = 0. The sick counter increments on each game tick while in SICK. It clears when the FSM leaves SICK, going to NEEDY or OK per the rules above.
  - SICK → DEAD when the sick counter reaches SICK_TICKS.
  - DEAD is absorbing: stats frozen, care ignored, decay stopped. Only rst_n exits it.
- ena low: prescaler, counters, FSM and edge detectors hold their values. Button transitions during ena low are not captured.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous).

## Timing
- tick is registered: it is high in the cycle after the prescaler holds TICK_DIV-1.
- Decay is applied at the same edge that raises tick, so the decremented stat is visible while tick = 1.
- Care latency: stat reflects a press one cycle after the first cycle btn_care[i] is sampled high.
- mood and alert are registered from stat: one cycle after the stat change.
- Max rate: one press per need every 2 cycles (high then low).

## Structure
- Shared package pet_pkg holds:
  - mood_t enum (MOOD_OK, MOOD_NEEDY, MOOD_SICK, MOOD_DEAD) with the encodings above.
  - Default parameter constants.
  - The LOW_TH derivation function.
- Sub-module pet_stat_cell, instantiated N_NEEDS times. It contains one saturating stat register with edge detector, decay input, care step and freeze input, and outputs its stat value plus is_low/is_zero flags.
- The top level holds the prescaler, decay counter, sick counter and mood FSM.

## Test plan
Settings for all scenarios: TICK_DIV=4, DECAY_TICKS=2, STAT_W=4, N_NEEDS=3, CARE_STEP=4, SICK_TICKS=3.
- Reset then ena=1 for 32 cycles → 8 tick pulses, all stats 15→11, mood OK, alert 0.
- Decay stat0 to 13, pulse btn_care[0] → stat0 = 15 next cycle (saturation); second press leaves 15.
- Let stats decay to 3 → mood = NEEDY and alert = 1 exactly one cycle after the stat shows 3.
- Press care on need 1 with stat1 = 5 in the same cycle as a decay → stat1 = 8.
- No care until stats reach 0 → SICK; after 3 ticks → DEAD. Presses and further ticks leave stats at 0. rst_n pulse → stats 15, mood OK.
- Hold btn_care[2] high across rst_n release → no increment. Drop ena for 20 cycles → tick stays 0 and all state is unchanged.
